// File: rtl/i_prefetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i_prefetch_sequencer
// Description : Arbitrates the instruction-side AXI read channel between
//               I-cache demand refills and sequential next-line prefetches
//               into the stream buffer. After each demand refill, up to
//               PF_DEPTH following lines are prefetched. A redirect (sb_flush)
//               drops the stream, but an outstanding burst is always drained.
// Revision    : 1.0 - initial release
// ============================================================================
module i_prefetch_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 4,
    parameter int PF_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_req_valid,
    input  logic [ADDR_WIDTH-1:0] ic_req_addr,
    output logic                  ic_req_ready,
    output logic                  ic_rdata_valid,
    output logic [DATA_WIDTH-1:0] ic_rdata,
    output logic                  ic_rdata_last,
    input  logic                  sb_full,
    input  logic                  sb_flush,
    output logic                  sb_fill_valid,
    output logic [ADDR_WIDTH-1:0] sb_fill_addr,
    output logic [DATA_WIDTH-1:0] sb_fill_data,
    output logic                  sb_fill_last,
    output logic                  mem_arvalid,
    output logic [ADDR_WIDTH-1:0] mem_araddr,
    input  logic                  mem_arready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rlast,
    output logic                  mem_rready
);

    localparam int c_BEAT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int c_BYTE_SHIFT = $clog2(DATA_WIDTH / 8);

    localparam logic [ADDR_WIDTH-1:0] c_LINE_BYTES = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);
    localparam logic [c_BEAT_W-1:0]   c_BEAT_ONE   = c_BEAT_W'(1);
    localparam logic [2:0]            c_PF_DEPTH   = 3'(PF_DEPTH);

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_DEM_ADDR = 3'd1;
    localparam logic [2:0] c_ST_DEM_DATA = 3'd2;
    localparam logic [2:0] c_ST_PF_ADDR  = 3'd3;
    localparam logic [2:0] c_ST_PF_DATA  = 3'd4;
    localparam logic [2:0] c_ST_PF_DRAIN = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_cur_addr;
    logic [ADDR_WIDTH-1:0] r_pf_next_addr;
    logic [2:0]            r_pf_remaining;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    // Set while draining a flushed prefetch whose address was not yet accepted
    logic                  r_drain_addr;

    logic w_beat;
    logic w_last;
    logic w_fill;
    logic [ADDR_WIDTH-1:0] w_beat_off;

    assign w_beat     = mem_rvalid && mem_rready;
    assign w_last     = w_beat && mem_rlast;
    assign w_beat_off = ADDR_WIDTH'(r_beat_cnt) << c_BYTE_SHIFT;

    // Sequencer state machine and address/prefetch bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_cur_addr     <= '0;
            r_pf_next_addr <= '0;
            r_pf_remaining <= 3'd0;
            r_beat_cnt     <= '0;
            r_drain_addr   <= 1'b0;
        end else begin
            // A redirect kills the remaining prefetch budget; later
            // assignments in this block (demand reload) take precedence.
            if (sb_flush) begin
                r_pf_remaining <= 3'd0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (ic_req_valid) begin
                        r_cur_addr <= ic_req_addr;
                        r_state    <= c_ST_DEM_ADDR;
                    end else if ((r_pf_remaining != 3'd0) && !sb_full && !sb_flush) begin
                        r_cur_addr <= r_pf_next_addr;
                        r_state    <= c_ST_PF_ADDR;
                    end
                end

                c_ST_DEM_ADDR: begin
                    if (mem_arready) begin
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_DEM_DATA;
                    end
                end

                c_ST_PF_ADDR: begin
                    if (sb_flush) begin
                        // Address still pending unless it is accepted this cycle
                        r_drain_addr <= !mem_arready;
                        r_beat_cnt   <= '0;
                        r_state      <= c_ST_PF_DRAIN;
                    end else if (mem_arready) begin
                        r_beat_cnt <= '0;
                        r_state    <= c_ST_PF_DATA;
                    end
                end

                c_ST_DEM_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                    end
                    if (w_last) begin
                        // New stream starts after the demand line, overriding a flush
                        r_pf_next_addr <= r_cur_addr + c_LINE_BYTES;
                        r_pf_remaining <= c_PF_DEPTH;
                        r_state        <= c_ST_IDLE;
                    end
                end

                c_ST_PF_DATA: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + c_BEAT_ONE;
                    end
                    if (w_last) begin
                        r_pf_next_addr <= r_pf_next_addr + c_LINE_BYTES;
                        if (!sb_flush) begin
                            r_pf_remaining <= r_pf_remaining - 3'd1;
                        end
                        r_state <= c_ST_IDLE;
                    end else if (sb_flush) begin
                        r_drain_addr <= 1'b0;
                        r_state      <= c_ST_PF_DRAIN;
                    end
                end

                c_ST_PF_DRAIN: begin
                    if (r_drain_addr) begin
                        if (mem_arready) begin
                            r_drain_addr <= 1'b0;
                        end
                    end else if (w_last) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Channel-control outputs decode registered state only
    assign ic_req_ready = (r_state == c_ST_IDLE);
    assign mem_arvalid  = (r_state == c_ST_DEM_ADDR) || (r_state == c_ST_PF_ADDR) ||
                          ((r_state == c_ST_PF_DRAIN) && r_drain_addr);
    assign mem_araddr   = mem_arvalid ? r_cur_addr : '0;
    assign mem_rready   = (r_state == c_ST_DEM_DATA) || (r_state == c_ST_PF_DATA) ||
                          ((r_state == c_ST_PF_DRAIN) && !r_drain_addr);

    // Read data is steered combinationally to the demand or prefetch consumer
    assign ic_rdata_valid = (r_state == c_ST_DEM_DATA) && mem_rvalid;
    assign ic_rdata       = ic_rdata_valid ? mem_rdata : '0;
    assign ic_rdata_last  = ic_rdata_valid && mem_rlast;

    // A flush in the same cycle already hides the beat from the stream buffer
    assign w_fill        = (r_state == c_ST_PF_DATA) && mem_rvalid && !sb_flush;
    assign sb_fill_valid = w_fill;
    assign sb_fill_addr  = w_fill ? (r_cur_addr + w_beat_off) : '0;
    assign sb_fill_data  = w_fill ? mem_rdata : '0;
    assign sb_fill_last  = w_fill && mem_rlast;

endmodule
`default_nettype wire

// File: tb/tb_i_prefetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i_prefetch_sequencer
// Description : Directed self-checking bench for i_prefetch_sequencer with a
//               simple in-order AXI read slave and output logging monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i_prefetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ic_req_valid;
    logic [31:0] ic_req_addr;
    logic        ic_req_ready;
    logic        ic_rdata_valid;
    logic [31:0] ic_rdata;
    logic        ic_rdata_last;
    logic        sb_full;
    logic        sb_flush;
    logic        sb_fill_valid;
    logic [31:0] sb_fill_addr;
    logic [31:0] sb_fill_data;
    logic        sb_fill_last;
    logic        mem_arvalid;
    logic [31:0] mem_araddr;
    logic        mem_arready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rlast;
    logic        mem_rready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] ar_q[$];
    logic [31:0] ic_data_q[$];
    logic        ic_last_q[$];
    logic [31:0] sb_addr_q[$];
    logic [31:0] sb_data_q[$];
    logic        sb_last_q[$];
    int          drain_cnt;

    i_prefetch_sequencer #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN(4), .PF_DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_rdata_valid(ic_rdata_valid), .ic_rdata(ic_rdata), .ic_rdata_last(ic_rdata_last),
        .sb_full(sb_full), .sb_flush(sb_flush),
        .sb_fill_valid(sb_fill_valid), .sb_fill_addr(sb_fill_addr),
        .sb_fill_data(sb_fill_data), .sb_fill_last(sb_fill_last),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arready(mem_arready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rlast(mem_rlast),
        .mem_rready(mem_rready)
    );

    always #5 clk = ~clk;

    // Memory contents: each word is its byte address with a fixed tag
    function automatic logic [31:0] dfn(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // In-order AXI read slave: immediate arready, back-to-back 4-beat bursts
    initial begin : slave
        logic [31:0] pend[$];
        int          beat;
        logic        s_rst, s_ar, s_r;
        logic [31:0] s_addr;
        logic [31:0] ba;
        beat = 0;
        mem_arready = 1'b1;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_rlast   = 1'b0;
        forever begin
            @(negedge clk); #1;
            s_rst  = rst;
            s_ar   = mem_arvalid && mem_arready;
            s_addr = mem_araddr;
            s_r    = mem_rvalid && mem_rready;
            @(posedge clk); #1;
            if (s_rst) begin
                pend.delete();
                beat = 0;
            end else begin
                if (s_r) begin
                    beat++;
                    if (beat == 4) begin
                        void'(pend.pop_front());
                        beat = 0;
                    end
                end
                if (s_ar) pend.push_back(s_addr);
            end
            if (pend.size() > 0) begin
                ba         = pend[0] + 32'(beat * 4);
                mem_rvalid = 1'b1;
                mem_rdata  = dfn(ba);
                mem_rlast  = (beat == 3);
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
                mem_rlast  = 1'b0;
            end
        end
    end

    // Output logger
    initial begin : monitor
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                if (mem_arvalid && mem_arready) ar_q.push_back(mem_araddr);
                if (ic_rdata_valid) begin
                    ic_data_q.push_back(ic_rdata);
                    ic_last_q.push_back(ic_rdata_last);
                end
                if (sb_fill_valid) begin
                    sb_addr_q.push_back(sb_fill_addr);
                    sb_data_q.push_back(sb_fill_data);
                    sb_last_q.push_back(sb_fill_last);
                end
                if (mem_rvalid && mem_rready && !sb_fill_valid && !ic_rdata_valid) drain_cnt++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        ar_q.delete(); ic_data_q.delete(); ic_last_q.delete();
        sb_addr_q.delete(); sb_data_q.delete(); sb_last_q.delete();
        drain_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; ic_req_valid = 1'b0; ic_req_addr = '0; sb_full = 1'b0; sb_flush = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic issue_demand(input logic [31:0] a);
        int n;
        n = 0;
        ic_req_addr  = a;
        ic_req_valid = 1'b1;
        while (!ic_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL demand_accept: ready never seen for addr %h", a);
        end
        @(negedge clk);
        ic_req_valid = 1'b0;
        ic_req_addr  = '0;
    endtask

    task automatic wait_fill();
        int n;
        n = 0;
        while (!sb_fill_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 100) begin
            n_fail++;
            $display("FAIL wait_fill: sb_fill_valid got 0 required 1 within 100 cycles");
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if (ic_req_ready !== 1'b1 || mem_arvalid !== 1'b0 || mem_rready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ready/arvalid/rready got %b%b%b required 100",
                     ic_req_ready, mem_arvalid, mem_rready);
        end
        issue_demand(32'h100);
        wait_fill();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ic_req_ready !== 1'b1 || mem_arvalid !== 1'b0 || mem_rready !== 1'b0 ||
            sb_fill_valid !== 1'b0 || ic_rdata_valid !== 1'b0 || mem_araddr !== 32'h0 ||
            sb_fill_addr !== 32'h0 || sb_fill_data !== 32'h0 || ic_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_pf: rdy=%b arv=%b rrdy=%b fv=%b iv=%b araddr=%h faddr=%h required 1,0,0,0,0,0,0",
                     ic_req_ready, mem_arvalid, mem_rready, sb_fill_valid, ic_rdata_valid, mem_araddr, sb_fill_addr);
        end
        n_tests++;
        if (dut.r_pf_remaining !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_pf_remaining: got %0d required 0", dut.r_pf_remaining);
        end
        rst = 1'b0;
        clear_logs();
        repeat (20) @(negedge clk);
        n_tests++;
        if (ar_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_prefetch: arvalid count got %0d required 0", ar_q.size());
        end
    endtask

    task automatic test_demand_prefetch();
        logic [31:0] exp_ar[3];
        do_reset();
        issue_demand(32'h100);
        n_tests++;
        if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h100) begin
            n_fail++;
            $display("FAIL demand_latency: arvalid=%b araddr=%h required 1 00000100", mem_arvalid, mem_araddr);
        end
        repeat (40) @(negedge clk);
        exp_ar[0] = 32'h100; exp_ar[1] = 32'h110; exp_ar[2] = 32'h120;
        n_tests++;
        if (ar_q.size() != 3) begin
            n_fail++;
            $display("FAIL pf_ar_count: got %0d required 3", ar_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (ar_q[i] !== exp_ar[i]) begin
                    n_fail++;
                    $display("FAIL pf_araddr[%0d]: got %h required %h", i, ar_q[i], exp_ar[i]);
                end
            end
        end
        n_tests++;
        if (ic_data_q.size() != 4) begin
            n_fail++;
            $display("FAIL dem_beats: got %0d required 4", ic_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_tests++;
                if (ic_data_q[i] !== dfn(32'h100 + 32'(4 * i)) || ic_last_q[i] !== (i == 3)) begin
                    n_fail++;
                    $display("FAIL dem_beat[%0d]: data %h last %b required %h %b", i, ic_data_q[i],
                             ic_last_q[i], dfn(32'h100 + 32'(4 * i)), (i == 3));
                end
            end
        end
        n_tests++;
        if (sb_addr_q.size() != 8) begin
            n_fail++;
            $display("FAIL pf_beats: got %0d required 8", sb_addr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_tests++;
                if (sb_addr_q[i] !== 32'h110 + 32'(4 * i) || sb_data_q[i] !== dfn(32'h110 + 32'(4 * i)) ||
                    sb_last_q[i] !== (i == 3 || i == 7)) begin
                    n_fail++;
                    $display("FAIL pf_beat[%0d]: addr %h data %h last %b required %h %h %b", i,
                             sb_addr_q[i], sb_data_q[i], sb_last_q[i], 32'h110 + 32'(4 * i),
                             dfn(32'h110 + 32'(4 * i)), (i == 3 || i == 7));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [31:0] exp_ar[5];
        do_reset();
        issue_demand(32'h100);
        wait_fill();
        ic_req_addr  = 32'h200;
        ic_req_valid = 1'b1;
        n = 0;
        while (!ic_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (sb_addr_q.size() != 4) begin
            n_fail++;
            $display("FAIL demand_wait: pf beats before ready got %0d required 4", sb_addr_q.size());
        end
        @(negedge clk);
        ic_req_valid = 1'b0;
        repeat (40) @(negedge clk);
        exp_ar[0] = 32'h100; exp_ar[1] = 32'h110; exp_ar[2] = 32'h200;
        exp_ar[3] = 32'h210; exp_ar[4] = 32'h220;
        n_tests++;
        if (ar_q.size() != 5) begin
            n_fail++;
            $display("FAIL b2b_ar_count: got %0d required 5", ar_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_tests++;
                if (ar_q[i] !== exp_ar[i]) begin
                    n_fail++;
                    $display("FAIL b2b_araddr[%0d]: got %h required %h", i, ar_q[i], exp_ar[i]);
                end
            end
        end
        n_tests++;
        if (ic_data_q.size() != 8) begin
            n_fail++;
            $display("FAIL b2b_dem_beats: got %0d required 8", ic_data_q.size());
        end
    endtask

    task automatic test_sb_full();
        int n;
        do_reset();
        sb_full = 1'b1;
        issue_demand(32'h100);
        repeat (20) @(negedge clk);
        n_tests++;
        if (ar_q.size() != 1) begin
            n_fail++;
            $display("FAIL full_block: arvalid count got %0d required 1", ar_q.size());
        end
        sb_full = 1'b0;
        n = 0;
        while (!mem_arvalid && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (mem_arvalid !== 1'b1 || mem_araddr !== 32'h110 || n > 2) begin
            n_fail++;
            $display("FAIL full_release: arvalid=%b araddr=%h after %0d cycles required 1 00000110 within 2",
                     mem_arvalid, mem_araddr, n);
        end
        repeat (40) @(negedge clk);
    endtask

    task automatic test_flush_drain();
        do_reset();
        issue_demand(32'h100);
        wait_fill();
        @(posedge clk); #2;
        sb_flush = 1'b1;
        @(negedge clk);
        n_tests++;
        if (sb_fill_valid !== 1'b0 || mem_rready !== 1'b1 || mem_rvalid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_beat2: fill_valid=%b rready=%b rvalid=%b required 0 1 1",
                     sb_fill_valid, mem_rready, mem_rvalid);
        end
        @(posedge clk); #2;
        sb_flush = 1'b0;
        repeat (30) @(negedge clk);
        n_tests++;
        if (sb_addr_q.size() != 1) begin
            n_fail++;
            $display("FAIL flush_fill_count: got %0d required 1", sb_addr_q.size());
        end
        n_tests++;
        if (drain_cnt != 3) begin
            n_fail++;
            $display("FAIL flush_drained: beats got %0d required 3", drain_cnt);
        end
        n_tests++;
        if (ar_q.size() != 2 || ic_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_stop: ar count %0d ready %b required 2 1", ar_q.size(), ic_req_ready);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        issue_demand(32'hFFFF_FFF0);
        repeat (40) @(negedge clk);
        n_tests++;
        if (ar_q.size() != 3) begin
            n_fail++;
            $display("FAIL wrap_ar_count: got %0d required 3", ar_q.size());
        end else begin
            n_tests++;
            if (ar_q[1] !== 32'h0 || ar_q[2] !== 32'h10) begin
                n_fail++;
                $display("FAIL wrap_araddr: got %h %h required 00000000 00000010", ar_q[1], ar_q[2]);
            end
        end
        n_tests++;
        if (sb_addr_q.size() != 8) begin
            n_fail++;
            $display("FAIL wrap_fill_count: got %0d required 8", sb_addr_q.size());
        end else begin
            n_tests++;
            if (sb_addr_q[0] !== 32'h0 || sb_addr_q[7] !== 32'h1C) begin
                n_fail++;
                $display("FAIL wrap_fill_addr: got %h %h required 00000000 0000001c", sb_addr_q[0], sb_addr_q[7]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; ic_req_valid = 1'b0; ic_req_addr = '0; sb_full = 1'b0; sb_flush = 1'b0;
        drain_cnt = 0;
        @(negedge clk);
        test_reset();
        test_demand_prefetch();
        test_back_to_back();
        test_sb_full();
        test_flush_drain();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i_prefetch_sequencer.md
# i_prefetch_sequencer

Sequences all instruction-side memory reads. It arbitrates the single AXI read channel between I-cache demand refills and sequential next-line prefetches that fill the instruction stream buffer. After each demand refill it issues up to PF_DEPTH line prefetches, and it drops them on a pipeline redirect. It sits between the I-cache/stream buffer pair and the instruction memory AXI read master ports.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, beat width; one beat is one instruction
- BURST_LEN, 4, beats per cache line (power of 2)
- PF_DEPTH, 2, lines prefetched after each demand refill (1..7)

Ports (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- ic_req_valid  in  1  I-cache miss request
- ic_req_addr  in  ADDR_WIDTH  miss line address, line-aligned
- ic_req_ready  out  1  request accepted when valid&ready
- ic_rdata_valid  out  1  demand beat valid
- ic_rdata  out  DATA_WIDTH  demand beat data
- ic_rdata_last  out  1  final demand beat
- sb_full  in  1  stream buffer cannot take another line
- sb_flush  in  1  redirect; abandon prefetch stream
- sb_fill_valid  out  1  prefetch beat valid
- sb_fill_addr  out  ADDR_WIDTH  byte address of the prefetch beat
- sb_fill_data  out  DATA_WIDTH  prefetch beat data
- sb_fill_last  out  1  final beat of the prefetched line
- mem_arvalid  out  1  AXI read address valid
- mem_araddr  out  ADDR_WIDTH  AXI read address (line-aligned)
- mem_arready  in  1  AXI read address ready
- mem_rvalid  in  1  AXI read data valid
- mem_rdata  in  DATA_WIDTH  AXI read data
- mem_rlast  in  1  AXI last beat
- mem_rready  out  1  AXI read data ready

## Operation
- LINE_BYTES = BURST_LEN*DATA_WIDTH/8. All address arithmetic is modulo 2^ADDR_WIDTH (wraps silently).
- States: IDLE, DEM_ADDR, DEM_DATA, PF_ADDR, PF_DATA, PF_DRAIN.
- Registers: cur_addr, pf_next_addr, pf_remaining (3 bits), beat_cnt (log2 BURST_LEN bits).
- IDLE: ic_req_ready=1.
  - ic_req_valid → capture ic_req_addr into cur_addr, go to DEM_ADDR.
  - Otherwise, if pf_remaining>0, !sb_full and !sb_flush → cur_addr=pf_next_addr, go to PF_ADDR.
  - Demand always has priority over prefetch.
- DEM_ADDR/PF_ADDR: mem_arvalid=1, mem_araddr=cur_addr. On mem_arready go to DEM_DATA or PF_DATA; beat_cnt=0.
- DEM_DATA: mem_rready=1. Each mem_rvalid beat is forwarded to ic_rdata*. On the rlast beat:
  - pf_next_addr=cur_addr+LINE_BYTES
  - pf_remaining=PF_DEPTH
  - go to IDLE.
- PF_DATA: mem_rready=1. Each beat is forwarded to sb_fill_*, with sb_fill_addr=cur_addr+beat_cnt*(DATA_WIDTH/8). On the rlast beat:
  - pf_next_addr+=LINE_BYTES
  - pf_remaining-=1
  - go to IDLE.
- sb_flush: sets pf_remaining=0 in any state.
  - In PF_ADDR or PF_DATA, go to PF_DRAIN. An outstanding AXI burst is never cancelled.
  - PF_DRAIN holds mem_arvalid/mem_rready as the originating state required, suppresses sb_fill_valid, and returns to IDLE after rlast.
  - In DEM_* states the demand completes normally. The reload at demand completion overrides a same-cycle flush, because the demand belongs to the new stream.
- A demand arriving during a prefetch waits (ic_req_ready=0) until IDLE.
- sb_full is sampled only in IDLE. A line already in flight always completes.
- mem_rlast terminates the burst. beat_cnt is used only for addressing; a beat_cnt wrap before rlast is a memory protocol error and is not checked.

## Timing
- Reset values: state=IDLE, pf_remaining=0, every other register 0. All outputs are 0 except ic_req_ready=1.
- ic_req_ready, mem_arvalid, mem_araddr and mem_rready are decoded from registered state only (no input-to-output path).
- The rdata forwarding path is combinational: ic_rdata*/sb_fill* equal mem_r* in the same cycle, gated by state.
- Demand latency: accept at cycle N, mem_arvalid at N+1. Data state is entered the cycle after the arready handshake. IDLE is reached the cycle after rlast.
- Earliest prefetch arvalid is 2 cycles after demand rlast (IDLE, then PF_ADDR).
- ic_req_valid and a prefetch-eligible IDLE in the same cycle: the demand wins.

## Test plan
- Reset mid-PF_DATA → next cycle state IDLE, all outputs 0, ic_req_ready=1, pf_remaining=0.
- Demand 0x100, memory returns 4 beats (arready immediate) → 4 ic_rdata beats with last on the 4th. Then arvalid at 0x110 and 0x120, with sb_fill_addr sequence 0x110,0x114,0x118,0x11C then 0x120..0x12C. No third prefetch.
- Demand 0x200 raised during the 0x110 PF_DATA → ic_req_ready stays 0 until that burst's rlast. Then 0x200 is issued; the next prefetch issued is 0x210, and 0x120 is never issued.
- sb_full=1 after a demand to 0x100 → no arvalid issued. Deassert → 0x110 is issued within 2 cycles.
- sb_flush on the 2nd beat of prefetch 0x110 → beats 2-4 are accepted (rready=1) with sb_fill_valid=0, then IDLE with no further arvalid.
- Demand 0xFFFFFFF0 → the first prefetch araddr is 0x00000000.
